// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, oversampling constants, default frame width.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  LAST_TICK  = 4'd15;
  localparam int unsigned FRAME_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and stop-bit framing check.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of data and stop bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = FRAME_BITS,
  parameter int unsigned SAMPLE_MID = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_rx,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int unsigned     IdxW    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [3:0]      MidTick = 4'(SAMPLE_MID);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);

  logic                 rxd_s;
  uart_state_e          state;
  logic [3:0]           cnt;
  logic [IdxW-1:0]      bit_idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0]           samp;
  logic                 pend;
  logic                 stop_pend;
`endif

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (i_rxd),
    .q     (rxd_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      cnt         <= 4'd0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_data      <= '0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      samp        <= 2'b00;
      pend        <= 1'b0;
      stop_pend   <= 1'b0;
`endif
    end else begin
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (state)
        StIdle: begin
          if (!rxd_s) begin
            state  <= StStart;
            cnt    <= 4'd0;
            o_busy <= 1'b1;
          end
        end
        StStart: begin
          if (i_clk_rx) begin
            if (cnt == MidTick) begin
              cnt <= 4'd0;
              if (rxd_s) begin
                state  <= StIdle;
                o_busy <= 1'b0;
              end else begin
                state   <= StData;
                bit_idx <= '0;
`ifdef UART_RX_MAJORITY_EN
                pend      <= 1'b0;
                stop_pend <= 1'b0;
`endif
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
`ifdef UART_RX_MAJORITY_EN
        // Bit k is resolved on the cnt==0 tick of the following bit period.
        StData: begin
          if (i_clk_rx) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd0 && pend) begin
              shreg <= {maj3(samp[0], samp[1], rxd_s), shreg[DATA_BITS-1:1]};
              pend  <= 1'b0;
            end
            if (cnt == LAST_TICK - 4'd1) samp[0] <= rxd_s;
            if (cnt == LAST_TICK) begin
              samp[1] <= rxd_s;
              pend    <= 1'b1;
              if (bit_idx == LastIdx) begin
                bit_idx <= '0;
                state   <= StStop;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
        end
        StStop: begin
          if (i_clk_rx) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd0 && pend) begin
              pend <= 1'b0;
              if (stop_pend) begin
                stop_pend <= 1'b0;
                cnt       <= 4'd0;
                if (maj3(samp[0], samp[1], rxd_s)) begin
                  o_data     <= shreg;
                  o_rx_valid <= 1'b1;
                  state      <= StIdle;
                  o_busy     <= 1'b0;
                end else begin
                  o_frame_err <= 1'b1;
                  state       <= StBreak;
                end
              end else begin
                shreg <= {maj3(samp[0], samp[1], rxd_s), shreg[DATA_BITS-1:1]};
              end
            end
            if (cnt == LAST_TICK - 4'd1) samp[0] <= rxd_s;
            if (cnt == LAST_TICK) begin
              samp[1]   <= rxd_s;
              pend      <= 1'b1;
              stop_pend <= 1'b1;
            end
          end
        end
`else
        StData: begin
          if (i_clk_rx) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_TICK) begin
              shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
              if (bit_idx == LastIdx) begin
                bit_idx <= '0;
                state   <= StStop;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
        end
        StStop: begin
          if (i_clk_rx) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_TICK) begin
              cnt <= 4'd0;
              if (rxd_s) begin
                o_data     <= shreg;
                o_rx_valid <= 1'b1;
                state      <= StIdle;
                o_busy     <= 1'b0;
              end else begin
                o_frame_err <= 1'b1;
                state       <= StBreak;
              end
            end
          end
        end
`endif
        // Hold here while the line stays low so a break cannot retrigger frames.
        StBreak: begin
          if (rxd_s) begin
            state  <= StIdle;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= StIdle;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (8N1, 16 ticks per bit, tick every 8 clocks).
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_clk_rx;
  logic       i_rxd;
  logic [7:0] o_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_busy;

  int vectors    = 0;
  int miscompares = 0;

  int         n_valid   = 0;
  int         n_err     = 0;
  int         n_overlap = 0;
  int         n_long    = 0;
  logic [7:0] last_data = 8'h00;
  logic       prev_valid = 1'b0;
  logic       prev_err   = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_BITS  (8),
    .SAMPLE_MID (7)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_clk_rx    (i_clk_rx),
    .i_rxd       (i_rxd),
    .o_data      (o_data),
    .o_rx_valid  (o_rx_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
  );

  // One-clock tick every 8 clocks, changed on the falling edge.
  initial begin
    i_clk_rx = 1'b0;
    forever begin
      repeat (7) @(negedge clk);
      i_clk_rx = 1'b1;
      @(negedge clk);
      i_clk_rx = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (o_rx_valid) begin
      n_valid   <= n_valid + 1;
      last_data <= o_data;
    end
    if (o_frame_err) n_err <= n_err + 1;
    if (o_rx_valid && o_frame_err) n_overlap <= n_overlap + 1;
    if ((o_rx_valid && prev_valid) || (o_frame_err && prev_err)) n_long <= n_long + 1;
    prev_valid <= o_rx_valid;
    prev_err   <= o_frame_err;
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!i_clk_rx) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    i_rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      i_rxd = d[i];
      wait_ticks(16);
    end
    i_rxd = stop;
    wait_ticks(16);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (o_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 00", o_data);
    end
    vectors++;
    if (o_rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b expected 0", o_rx_valid);
    end
    vectors++;
    if (o_frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got %b expected 0", o_frame_err);
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
    reset = 1'b1;
    wait_ticks(4);
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_busy: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_single_byte();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'hA5, 1'b1);
    wait_ticks(2);
    vectors++;
    if (n_valid !== v0 + 1) begin
      miscompares++;
      $display("FAIL a5_valid_count: got %0d expected %0d", n_valid, v0 + 1);
    end
    vectors++;
    if (o_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_data: got %h expected a5", o_data);
    end
    vectors++;
    if (last_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_pulse_data: got %h expected a5", last_data);
    end
    vectors++;
    if (n_err !== e0) begin
      miscompares++;
      $display("FAIL a5_err_count: got %0d expected %0d", n_err, e0);
    end
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL a5_busy_after: got %b expected 0", o_busy);
    end
  endtask

  task automatic test_false_start();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    i_rxd = 1'b0;
    wait_ticks(2);
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fs_busy_start: got %b expected 1", o_busy);
    end
    wait_ticks(2);
    i_rxd = 1'b1;
    wait_ticks(8);
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fs_busy_abort: got %b expected 0", o_busy);
    end
    vectors++;
    if (n_valid !== v0 || n_err !== e0) begin
      miscompares++;
      $display("FAIL fs_pulses: got valid=%0d err=%0d expected valid=%0d err=%0d",
               n_valid, n_err, v0, e0);
    end
    vectors++;
    if (o_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL fs_data: got %h expected a5", o_data);
    end
  endtask

  task automatic test_frame_error();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h3C, 1'b0);
    wait_ticks(24);
    vectors++;
    if (n_err !== e0 + 1) begin
      miscompares++;
      $display("FAIL fe_err_count: got %0d expected %0d", n_err, e0 + 1);
    end
    vectors++;
    if (n_valid !== v0) begin
      miscompares++;
      $display("FAIL fe_valid_count: got %0d expected %0d", n_valid, v0);
    end
    vectors++;
    if (o_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL fe_data_kept: got %h expected a5", o_data);
    end
    vectors++;
    if (o_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fe_break_busy: got %b expected 1", o_busy);
    end
    i_rxd = 1'b1;
    wait_ticks(2);
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL fe_break_exit: got %b expected 0", o_busy);
    end
    send_frame(8'h81, 1'b1);
    wait_ticks(2);
    vectors++;
    if (o_data !== 8'h81 || n_valid !== v0 + 1) begin
      miscompares++;
      $display("FAIL fe_next_frame: got data=%h valid=%0d expected data=81 valid=%0d",
               o_data, n_valid, v0 + 1);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    send_frame(8'h00, 1'b1);
    vectors++;
    if (n_valid !== v0 + 1 || last_data !== 8'h00) begin
      miscompares++;
      $display("FAIL b2b_first: got valid=%0d data=%h expected valid=%0d data=00",
               n_valid, last_data, v0 + 1);
    end
    send_frame(8'hFF, 1'b1);
    wait_ticks(2);
    vectors++;
    if (n_valid !== v0 + 2 || last_data !== 8'hFF) begin
      miscompares++;
      $display("FAIL b2b_second: got valid=%0d data=%h expected valid=%0d data=ff",
               n_valid, last_data, v0 + 2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    logic [7:0] d;
    d = 8'h55;
    i_rxd = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      i_rxd = d[i];
      wait_ticks(16);
    end
    i_rxd = d[4];
    wait_ticks(8);
    reset = 1'b0;
    #1;
    vectors++;
    if (o_data !== 8'h00 || o_rx_valid !== 1'b0 || o_frame_err !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got data=%h valid=%b err=%b busy=%b expected all 0",
               o_data, o_rx_valid, o_frame_err, o_busy);
    end
    v0 = n_valid;
    e0 = n_err;
    repeat (4) @(posedge clk);
    #1;
    i_rxd = 1'b1;
    reset = 1'b1;
    wait_ticks(20);
    vectors++;
    if (n_valid !== v0 || n_err !== e0) begin
      miscompares++;
      $display("FAIL rst_mid_pulses: got valid=%0d err=%0d expected valid=%0d err=%0d",
               n_valid, n_err, v0, e0);
    end
    send_frame(8'h66, 1'b1);
    wait_ticks(2);
    vectors++;
    if (o_data !== 8'h66 || n_valid !== v0 + 1) begin
      miscompares++;
      $display("FAIL rst_mid_next: got data=%h valid=%0d expected data=66 valid=%0d",
               o_data, n_valid, v0 + 1);
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    logic [7:0] d;
    logic [7:0] exp_data;
`ifdef UART_RX_MAJORITY_EN
    exp_data = 8'h0F;
`else
    exp_data = 8'h0D;
`endif
    d  = 8'h0F;
    v0 = n_valid;
    e0 = n_err;
    i_rxd = 1'b0;
    wait_ticks(16);
    i_rxd = d[0];
    wait_ticks(16);
    // Bit 1: single-tick low pulse landing on the cnt==15 sample tick.
    i_rxd = d[1];
    wait_ticks(7);
    i_rxd = 1'b0;
    wait_ticks(1);
    i_rxd = 1'b1;
    wait_ticks(8);
    for (int i = 2; i < 8; i++) begin
      i_rxd = d[i];
      wait_ticks(16);
    end
    i_rxd = 1'b1;
    wait_ticks(16);
    wait_ticks(2);
    vectors++;
    if (o_data !== exp_data) begin
      miscompares++;
      $display("FAIL glitch_data: got %h expected %h", o_data, exp_data);
    end
    vectors++;
    if (n_valid !== v0 + 1 || n_err !== e0) begin
      miscompares++;
      $display("FAIL glitch_pulses: got valid=%0d err=%0d expected valid=%0d err=%0d",
               n_valid, n_err, v0 + 1, e0);
    end
  endtask

  task automatic test_pulse_rules();
    vectors++;
    if (n_overlap !== 0) begin
      miscompares++;
      $display("FAIL pulse_overlap: got %0d expected 0", n_overlap);
    end
    vectors++;
    if (n_long !== 0) begin
      miscompares++;
      $display("FAIL pulse_width: got %0d expected 0", n_long);
    end
  endtask

  initial begin
    reset = 1'b0;
    i_rxd = 1'b1;
    test_reset();
    test_single_byte();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_glitch();
    test_pulse_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
